// File: rtl/rr_mux_arb_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_mux_arb_if
// Purpose  : Producer-side channels plus consumer-side output of rr_mux_arb.
// Revision : 1.0  initial release
// ============================================================================
interface rr_mux_arb_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SEL_W-1:0]   force_sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/rr_mux_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_mux_arb
// Purpose  : N-channel registered mux with round-robin/fixed-priority arbiter.
// Revision : 1.0  initial release
// ============================================================================
module rr_mux_arb #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int RR_MODE = 1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    rr_mux_arb_if.slave  bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [SEL_W:0]   c_n_ext = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] c_last  = SEL_W'(N - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic [N-1:0]     w_cand;
    logic [N-1:0]     w_grant;
    logic             w_found;
    logic [SEL_W-1:0] w_gidx;
    logic [SEL_W-1:0] w_base;
    logic [SEL_W:0]   w_try;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] w_sel_data;

    assign w_load_en = !r_out_valid || bus.out_ready;

    // An out-of-range force_sel matches no channel, leaving the set empty.
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_cand
            assign w_cand[i] = bus.in_valid[i] &&
                               (!bus.force_en || (bus.force_sel == SEL_W'(i)));
        end
    endgenerate

    assign w_base = (RR_MODE != 0) ? r_ptr : '0;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_try   = '0;
        for (int k = 0; k < N; k++) begin
            w_try = {1'b0, w_base} + (SEL_W+1)'(k);
            if (w_try >= c_n_ext) begin
                w_try = w_try - c_n_ext;
            end
            if (!w_found && w_cand[w_try[SEL_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_try[SEL_W-1:0];
            end
        end
    end

    assign w_grant      = w_found ? (N'(1) << w_gidx) : '0;
    assign bus.in_ready = w_load_en ? w_grant : '0;
    assign w_sel_data   = bus.in_data[w_gidx*WIDTH +: WIDTH];
    assign w_ptr_nxt    = (w_gidx == c_last) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_gidx;
                r_out_valid <= 1'b1;
                if (RR_MODE != 0) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rr_mux_arb
// Purpose  : Directed self-checking bench for rr_mux_arb (RR and fixed modes).
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_mux_arb;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_mux_arb_if #(.N(4), .WIDTH(8)) bus_rr ();
    rr_mux_arb_if #(.N(4), .WIDTH(8)) bus_fp ();

    rr_mux_arb #(.N(4), .WIDTH(8), .RR_MODE(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr.slave)
    );

    rr_mux_arb #(.N(4), .WIDTH(8), .RR_MODE(0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp.slave)
    );

    task automatic drive_rr(input logic [3:0] v, input logic [31:0] d,
                            input logic ordy, input logic fen, input logic [1:0] fsel);
        bus_rr.in_valid  = v;
        bus_rr.in_data   = d;
        bus_rr.out_ready = ordy;
        bus_rr.force_en  = fen;
        bus_rr.force_sel = fsel;
    endtask

    task automatic drive_fp(input logic [3:0] v, input logic [31:0] d, input logic ordy);
        bus_fp.in_valid  = v;
        bus_fp.in_data   = d;
        bus_fp.out_ready = ordy;
        bus_fp.force_en  = 1'b0;
        bus_fp.force_sel = 2'd0;
    endtask

    task automatic test_reset();
        drive_rr(4'h0, 32'h0, 1'b0, 1'b0, 2'd0);
        drive_fp(4'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (bus_rr.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_rr.out_valid); end
        total++; if (bus_rr.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus_rr.out_data); end
        total++; if (bus_rr.out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", bus_rr.out_sel); end
        total++; if (bus_fp.out_valid !== 1'b0) begin bad++; $display("FAIL reset_fp_valid got=%b exp=0", bus_fp.out_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        @(negedge clk);
        drive_rr(4'hF, 32'hA3A2A1A0, 1'b1, 1'b0, 2'd0);
        #1;
        total++; if (bus_rr.in_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got=%b exp=0001", bus_rr.in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_rdy = 4'b0001 << ((k + 1) % 4);
            total++; if (bus_rr.out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid k=%0d got=%b exp=1", k, bus_rr.out_valid); end
            total++; if (bus_rr.out_data !== 8'(8'hA0 + k % 4)) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, bus_rr.out_data, 8'(8'hA0 + k % 4)); end
            total++; if (bus_rr.out_sel !== 2'(k % 4)) begin bad++; $display("FAIL rr_sel k=%0d got=%0d exp=%0d", k, bus_rr.out_sel, k % 4); end
            total++; if (bus_rr.in_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus_rr.in_ready, exp_rdy); end
        end
        bus_rr.in_valid = 4'h0;
        @(negedge clk);
        total++; if (bus_rr.out_valid !== 1'b0) begin bad++; $display("FAIL rr_empty_valid got=%b exp=0", bus_rr.out_valid); end
        total++; if (bus_rr.out_data !== 8'hA0) begin bad++; $display("FAIL rr_empty_hold_data got=%h exp=a0", bus_rr.out_data); end
        total++; if (bus_rr.out_sel !== 2'd0) begin bad++; $display("FAIL rr_empty_hold_sel got=%0d exp=0", bus_rr.out_sel); end
    endtask

    task automatic test_wrap_skip();
        logic [1:0] exp_sel [3] = '{2'd1, 2'd2, 2'd1};
        // Pointer is 1 here; a lone ch3 request leaves it wrapped to 0.
        bus_rr.in_valid = 4'b1000;
        #1;
        total++; if (bus_rr.in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b exp=1000", bus_rr.in_ready); end
        @(negedge clk);
        total++; if (bus_rr.out_sel !== 2'd3) begin bad++; $display("FAIL wrap_sel3 got=%0d exp=3", bus_rr.out_sel); end
        total++; if (bus_rr.out_data !== 8'hA3) begin bad++; $display("FAIL wrap_data3 got=%h exp=a3", bus_rr.out_data); end
        bus_rr.in_valid = 4'b0110;
        #1;
        total++; if (bus_rr.in_ready !== 4'b0010) begin bad++; $display("FAIL skip_ready got=%b exp=0010", bus_rr.in_ready); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++; if (bus_rr.out_sel !== exp_sel[j]) begin bad++; $display("FAIL skip_sel j=%0d got=%0d exp=%0d", j, bus_rr.out_sel, exp_sel[j]); end
            total++; if (bus_rr.out_data !== (8'hA0 | 8'(exp_sel[j]))) begin bad++; $display("FAIL skip_data j=%0d got=%h exp=%h", j, bus_rr.out_data, 8'hA0 | 8'(exp_sel[j])); end
        end
        bus_rr.in_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        drive_rr(4'b0001, 32'h00000055, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        total++; if (bus_rr.out_data !== 8'h55) begin bad++; $display("FAIL bp_load got=%h exp=55", bus_rr.out_data); end
        drive_rr(4'hF, 32'h63626160, 1'b0, 1'b0, 2'd0);
        #1;
        total++; if (bus_rr.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready0 got=%b exp=0000", bus_rr.in_ready); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++; if (bus_rr.out_data !== 8'h55) begin bad++; $display("FAIL bp_hold_data j=%0d got=%h exp=55", j, bus_rr.out_data); end
            total++; if (bus_rr.out_sel !== 2'd0) begin bad++; $display("FAIL bp_hold_sel j=%0d got=%0d exp=0", j, bus_rr.out_sel); end
            total++; if (bus_rr.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid j=%0d got=%b exp=1", j, bus_rr.out_valid); end
            total++; if (bus_rr.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready j=%0d got=%b exp=0000", j, bus_rr.in_ready); end
        end
        bus_rr.out_ready = 1'b1;
        #1;
        total++; if (bus_rr.in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", bus_rr.in_ready); end
        @(negedge clk);
        total++; if (bus_rr.out_data !== 8'h61) begin bad++; $display("FAIL bp_next_data got=%h exp=61", bus_rr.out_data); end
        total++; if (bus_rr.out_sel !== 2'd1) begin bad++; $display("FAIL bp_next_sel got=%0d exp=1", bus_rr.out_sel); end
        @(negedge clk);
        total++; if (bus_rr.out_data !== 8'h62) begin bad++; $display("FAIL bp_nobubble_data got=%h exp=62", bus_rr.out_data); end
        total++; if (bus_rr.out_valid !== 1'b1) begin bad++; $display("FAIL bp_nobubble_valid got=%b exp=1", bus_rr.out_valid); end
        bus_rr.in_valid = 4'h0;
    endtask

    task automatic test_forced();
        drive_rr(4'hF, 32'h73727170, 1'b1, 1'b1, 2'd2);
        #1;
        total++; if (bus_rr.in_ready !== 4'b0100) begin bad++; $display("FAIL force_ready got=%b exp=0100", bus_rr.in_ready); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++; if (bus_rr.out_sel !== 2'd2) begin bad++; $display("FAIL force_sel j=%0d got=%0d exp=2", j, bus_rr.out_sel); end
            total++; if (bus_rr.out_data !== 8'h72) begin bad++; $display("FAIL force_data j=%0d got=%h exp=72", j, bus_rr.out_data); end
            total++; if (bus_rr.in_ready !== 4'b0100) begin bad++; $display("FAIL force_ready j=%0d got=%b exp=0100", j, bus_rr.in_ready); end
        end
        // Releasing the force exposes the pointer that forced grants left at 3.
        bus_rr.force_en = 1'b0;
        #1;
        total++; if (bus_rr.in_ready !== 4'b1000) begin bad++; $display("FAIL force_ptr_ready got=%b exp=1000", bus_rr.in_ready); end
        @(negedge clk);
        total++; if (bus_rr.out_sel !== 2'd3) begin bad++; $display("FAIL force_ptr_sel got=%0d exp=3", bus_rr.out_sel); end
        drive_rr(4'b1011, 32'h73727170, 1'b1, 1'b1, 2'd2);
        #1;
        total++; if (bus_rr.in_ready !== 4'b0000) begin bad++; $display("FAIL force_empty_ready got=%b exp=0000", bus_rr.in_ready); end
        @(negedge clk);
        total++; if (bus_rr.out_valid !== 1'b0) begin bad++; $display("FAIL force_empty_valid got=%b exp=0", bus_rr.out_valid); end
        total++; if (bus_rr.out_data !== 8'h73) begin bad++; $display("FAIL force_empty_hold got=%h exp=73", bus_rr.out_data); end
        drive_rr(4'h0, 32'h0, 1'b1, 1'b0, 2'd0);
    endtask

    task automatic test_fixed_priority();
        drive_fp(4'b1010, 32'h83008100, 1'b1);
        #1;
        total++; if (bus_fp.in_ready !== 4'b0010) begin bad++; $display("FAIL fp_ready got=%b exp=0010", bus_fp.in_ready); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total++; if (bus_fp.out_sel !== 2'd1) begin bad++; $display("FAIL fp_sel j=%0d got=%0d exp=1", j, bus_fp.out_sel); end
            total++; if (bus_fp.out_data !== 8'h81) begin bad++; $display("FAIL fp_data j=%0d got=%h exp=81", j, bus_fp.out_data); end
            total++; if (bus_fp.in_ready !== 4'b0010) begin bad++; $display("FAIL fp_ready j=%0d got=%b exp=0010", j, bus_fp.in_ready); end
        end
        drive_fp(4'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        drive_rr(4'hF, 32'hB3B2B1B0, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        total++; if (bus_rr.out_data !== 8'hB0) begin bad++; $display("FAIL mid_pre_data got=%h exp=b0", bus_rr.out_data); end
        rst_n = 1'b0;
        #1;
        total++; if (bus_rr.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", bus_rr.out_valid); end
        total++; if (bus_rr.out_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", bus_rr.out_data); end
        total++; if (bus_rr.out_sel !== 2'd0) begin bad++; $display("FAIL mid_rst_sel got=%0d exp=0", bus_rr.out_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus_rr.in_ready !== 4'b0001) begin bad++; $display("FAIL mid_post_ready got=%b exp=0001", bus_rr.in_ready); end
        @(negedge clk);
        total++; if (bus_rr.out_sel !== 2'd0) begin bad++; $display("FAIL mid_post_sel got=%0d exp=0", bus_rr.out_sel); end
        total++; if (bus_rr.out_data !== 8'hB0) begin bad++; $display("FAIL mid_post_data got=%h exp=b0", bus_rr.out_data); end
        drive_rr(4'h0, 32'h0, 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_backpressure();
        test_forced();
        test_fixed_priority();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
